// File: rtl/lock_pkg.sv
// Shared widths and key-loader FSM encoding for the locked-adder operand feeder.
package lock_pkg;

  localparam int LOCK_KEY_W  = 32;
  localparam int LOCK_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } key_state_t;

endpackage

// File: rtl/lock_key_shifter.sv
// Serial key shadow register with bit counter; o_done flags that the next accepted bit is the last.
module lock_key_shifter
  import lock_pkg::*;
#(
  parameter int KEY_W = LOCK_KEY_W,
  parameter int CNT_W = $clog2(KEY_W)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             i_clr,
  input  logic             i_shift,
  input  logic             i_bit,
  output logic [KEY_W-1:0] o_shadow,
  output logic             o_done
);

  logic [KEY_W-1:0] r_shadow;
  logic [CNT_W-1:0] r_cnt;

  // Shadow register and bit counter; clear wins over shift
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_shadow <= {KEY_W{1'b0}};
      r_cnt    <= {CNT_W{1'b0}};
    end else if (i_clr) begin
      r_shadow <= {KEY_W{1'b0}};
      r_cnt    <= {CNT_W{1'b0}};
    end else if (i_shift) begin
      r_shadow <= {r_shadow[KEY_W-2:0], i_bit};
      r_cnt    <= r_cnt + CNT_W'(1);
    end else begin
      r_shadow <= r_shadow;
      r_cnt    <= r_cnt;
    end
  end

  assign o_shadow = r_shadow;
  assign o_done   = (r_cnt == CNT_W'(KEY_W - 1));

endmodule

// File: rtl/lock_key_operand_loader.sv
// Loads the adder unlock key serially and commits it atomically; registers operand
// pairs behind a handshake that opens only once a key is committed.
module lock_key_operand_loader
  import lock_pkg::*;
#(
  parameter int DATA_W = LOCK_DATA_W,
  parameter int KEY_W  = LOCK_KEY_W,
  parameter int CNT_W  = $clog2(KEY_W)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              key_start_i,
  input  logic              key_bit_i,
  input  logic              key_bit_valid_i,
  output logic              key_busy_o,
  output logic              key_loaded_o,
  output logic              key_err_o,
  output logic [KEY_W-1:0]  key_o,
  input  logic              op_valid_i,
  output logic              op_ready_o,
  input  logic [DATA_W-1:0] add1_i,
  input  logic [DATA_W-1:0] add2_i,
  output logic [DATA_W-1:0] add1_o,
  output logic [DATA_W-1:0] add2_o,
  output logic              op_valid_o
);

  key_state_t        r_state;
  logic              r_key_loaded;
  logic              r_key_err;
  logic [KEY_W-1:0]  r_key;
  logic              r_op_valid;
  logic [DATA_W-1:0] r_add1;
  logic [DATA_W-1:0] r_add2;

  logic              w_clr;
  logic              w_shift;
  logic              w_done;
  logic              w_op_ready;
  logic [KEY_W-1:0]  w_shadow;

  // A restart request takes priority over a serial bit arriving in the same cycle
  always_comb begin
    w_clr   = 1'b0;
    w_shift = 1'b0;
    case (r_state)
      IDLE: begin
        w_clr = key_start_i;
      end
      SHIFT: begin
        if (key_start_i) begin
          w_clr = 1'b1;
        end else begin
          w_shift = key_bit_valid_i;
        end
      end
      default: begin
        w_clr   = 1'b0;
        w_shift = 1'b0;
      end
    endcase
  end

  lock_key_shifter #(
    .KEY_W (KEY_W),
    .CNT_W (CNT_W)
  ) u_shifter (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .i_clr    (w_clr),
    .i_shift  (w_shift),
    .i_bit    (key_bit_i),
    .o_shadow (w_shadow),
    .o_done   (w_done)
  );

  // Key FSM; key_o changes only in COMMIT so the adder never sees a partial key
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state      <= IDLE;
      r_key_loaded <= 1'b0;
      r_key_err    <= 1'b0;
      r_key        <= {KEY_W{1'b0}};
    end else begin
      case (r_state)
        IDLE: begin
          if (key_start_i) begin
            r_state      <= SHIFT;
            r_key_loaded <= 1'b0;
          end else begin
            r_state <= IDLE;
          end
        end
        SHIFT: begin
          if (key_start_i) begin
            r_key_err <= 1'b1;
          end else if (key_bit_valid_i && w_done) begin
            r_state <= COMMIT;
          end else begin
            r_state <= SHIFT;
          end
        end
        COMMIT: begin
          r_key        <= w_shadow;
          r_key_loaded <= 1'b1;
          r_key_err    <= 1'b0;
          r_state      <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign w_op_ready = r_key_loaded & (r_state == IDLE);

  // Operand capture stage; outputs hold between accepted pairs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_op_valid <= 1'b0;
      r_add1     <= {DATA_W{1'b0}};
      r_add2     <= {DATA_W{1'b0}};
    end else if (op_valid_i && w_op_ready) begin
      r_op_valid <= 1'b1;
      r_add1     <= add1_i;
      r_add2     <= add2_i;
    end else begin
      r_op_valid <= 1'b0;
      r_add1     <= r_add1;
      r_add2     <= r_add2;
    end
  end

  assign key_busy_o   = (r_state != IDLE);
  assign key_loaded_o = r_key_loaded;
  assign key_err_o    = r_key_err;
  assign key_o        = r_key;
  assign op_ready_o   = w_op_ready;
  assign add1_o       = r_add1;
  assign add2_o       = r_add2;
  assign op_valid_o   = r_op_valid;

endmodule

// File: tb/tb_lock_key_operand_loader.sv
// Directed plus randomized bench for lock_key_operand_loader against a transaction-level model.
module tb_lock_key_operand_loader;
  import lock_pkg::*;

  localparam int KW = 32;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          key_start = 1'b0;
  logic          key_bit = 1'b0;
  logic          key_bit_valid = 1'b0;
  logic          op_valid = 1'b0;
  logic [DW-1:0] a1 = '0;
  logic [DW-1:0] a2 = '0;

  logic          key_busy, key_loaded, key_err, op_ready, op_valid_o;
  logic [KW-1:0] key_out;
  logic [DW-1:0] add1_out, add2_out;

  lock_key_operand_loader dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .key_start_i     (key_start),
    .key_bit_i       (key_bit),
    .key_bit_valid_i (key_bit_valid),
    .key_busy_o      (key_busy),
    .key_loaded_o    (key_loaded),
    .key_err_o       (key_err),
    .key_o           (key_out),
    .op_valid_i      (op_valid),
    .op_ready_o      (op_ready),
    .add1_i          (a1),
    .add2_i          (a2),
    .add1_o          (add1_out),
    .add2_o          (add2_out),
    .op_valid_o      (op_valid_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  // Model: last committed key, loaded/error flags, last accepted operand pair
  logic [KW-1:0] m_key = '0;
  logic          m_loaded = 1'b0;
  logic          m_err = 1'b0;
  logic [DW-1:0] m_a1 = '0;
  logic [DW-1:0] m_a2 = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, key_busy, 0);
    chk({tag, "_loaded"}, key_loaded, 0);
    chk({tag, "_err"}, key_err, 0);
    chk({tag, "_key"}, key_out, 0);
    chk({tag, "_ready"}, op_ready, 0);
    chk({tag, "_add1"}, add1_out, 0);
    chk({tag, "_add2"}, add2_out, 0);
    chk({tag, "_opv"}, op_valid_o, 0);
  endtask

  // Offer (or withhold) one pair for one cycle while the loader is idle
  task automatic op_step(input logic v, input logic [DW-1:0] x, input logic [DW-1:0] y);
    logic acc;
    op_valid = v; a1 = x; a2 = y;
    acc = v & m_loaded;
    chk("op_ready", op_ready, m_loaded);
    tick;
    if (acc) begin m_a1 = x; m_a2 = y; end
    chk("op_valid_o", op_valid_o, acc);
    chk("add1_o", add1_out, m_a1);
    chk("add2_o", add2_out, m_a2);
    op_valid = 1'b0;
  endtask

  // Start a load and shift n bits of k without completing it
  task automatic partial_load(input logic [KW-1:0] k, input int n);
    key_start = 1'b1;
    tick;
    key_start = 1'b0;
    m_loaded = 1'b0;
    for (int i = KW - 1; i >= KW - n; i--) begin
      key_bit_valid = 1'b1; key_bit = k[i];
      tick;
      chk("partial_key_hold", key_out, m_key);
    end
    key_bit_valid = 1'b0;
  endtask

  // gap_mode: 0 no gaps, 1 gap before every bit, 2 random gaps
  task automatic load_key(input logic [KW-1:0] k, input int gap_mode, input bit restart, input bit with_op);
    logic          exp_err;
    logic [DW-1:0] x, y;
    bit            gap;
    exp_err = m_err | restart;
    key_start = 1'b1;
    if (restart) begin key_bit_valid = 1'b1; key_bit = 1'($urandom); end
    if (with_op) begin
      x = DW'($urandom); y = DW'($urandom);
      op_valid = 1'b1; a1 = x; a2 = y;
      chk("start_ready", op_ready, m_loaded);
      if (m_loaded) begin m_a1 = x; m_a2 = y; end
    end
    tick;
    if (with_op) begin
      chk("start_opv", op_valid_o, 1);
      chk("start_add1", add1_out, m_a1);
      chk("start_add2", add2_out, m_a2);
    end
    key_start = 1'b0; key_bit_valid = 1'b0; op_valid = 1'b0;
    m_loaded = 1'b0;
    chk("s_busy", key_busy, 1);
    chk("s_loaded", key_loaded, 0);
    chk("s_ready", op_ready, 0);
    chk("s_err", key_err, exp_err);
    for (int i = KW - 1; i >= 0; i--) begin
      gap = (gap_mode == 1) || (gap_mode == 2 && $urandom_range(0, 1) == 1);
      if (gap) begin
        key_bit_valid = 1'b0; key_bit = ~k[i];
        tick;
        chk("gap_key_hold", key_out, m_key);
      end
      key_bit_valid = 1'b1; key_bit = k[i];
      tick;
      chk("bit_key_hold", key_out, m_key);
      chk("bit_loaded", key_loaded, 0);
      chk("bit_err", key_err, exp_err);
    end
    key_bit_valid = 1'b0; key_bit = 1'($urandom);
    key_start = 1'b1;
    chk("commit_busy", key_busy, 1);
    tick;
    key_start = 1'b0;
    m_key = k; m_loaded = 1'b1; m_err = 1'b0;
    chk("done_key", key_out, m_key);
    chk("done_loaded", key_loaded, 1);
    chk("done_err", key_err, 0);
    chk("done_busy", key_busy, 0);
    chk("done_ready", op_ready, 1);
  endtask

  initial begin
    logic [KW-1:0] rk;
    rst_n = 1'b0;
    tick; tick;
    chk_all_zero("reset");
    rst_n = 1'b1;
    tick;
    chk_all_zero("post_reset");

    op_step(1'b1, 16'h29AF, 16'h7A1B);
    op_step(1'b1, 16'h29AF, 16'h7A1B);
    load_key(32'h967444F0, 0, 1'b0, 1'b0);
    op_step(1'b1, 16'h29AF, 16'h7A1B);
    op_step(1'b0, 16'h0000, 16'h0000);

    load_key(32'h3C5A_0F96, 1, 1'b0, 1'b1);
    op_step(1'b0, 16'h1111, 16'h2222);

    partial_load(32'hA5A5_5A5A, 10);
    load_key(32'h0000FFFF, 0, 1'b1, 1'b0);

    op_step(1'b1, 16'h8116, 16'h1CCE);
    op_step(1'b1, 16'h4482, 16'h3BCD);
    op_step(1'b1, 16'h8943, 16'hFFFF);
    op_step(1'b0, 16'h0000, 16'h0000);

    for (int r = 0; r < 4; r++) begin
      load_key(KW'($urandom), 2, 1'b0, 1'($urandom));
      for (int j = 0; j < 6; j++) begin
        op_step(1'($urandom), DW'($urandom), DW'($urandom));
      end
    end

    rk = KW'($urandom);
    partial_load(rk, 20);
    #1;
    rst_n = 1'b0;
    #1;
    m_key = '0; m_loaded = 1'b0; m_err = 1'b0; m_a1 = '0; m_a2 = '0;
    chk_all_zero("async_reset");
    tick;
    rst_n = 1'b1;
    tick;
    chk_all_zero("after_abort_reset");
    op_step(1'b1, 16'hBEEF, 16'hCAFE);
    load_key(rk, 0, 1'b0, 1'b0);
    op_step(1'b1, 16'hBEEF, 16'hCAFE);
    op_step(1'b0, 16'h0000, 16'h0000);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
